// File: rtl/program_loader_if.sv
// Byte-stream and instruction-memory write bundle for the program loader.
// The slave modport is the loader itself; the master modport is whatever
// feeds the byte stream and observes the memory write and status signals.
interface program_loader_if #(
    parameter int unsigned ADDR_W = 10
) ();
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  cpu_hold,
        input  done,
        input  error
    );

    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output cpu_hold,
        output done,
        output error
    );
endinterface

// File: rtl/program_loader.sv
// Boot-time instruction-memory writer. Parses a framed byte stream
// (SYNC, LEN_HI, LEN_LO, LEN big-endian words, XOR checksum), writes each
// word to consecutive word addresses and holds the CPU pipeline until a
// frame has been loaded and its checksum verified.
// The interface instance must be built with the same ADDR_W as this module.
module program_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic            clk,
    input  logic            rst_n,
    program_loader_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CHECK  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERROR  = 3'd7
    } state_t;

    // Largest accepted length: exactly the memory capacity in words.
    localparam logic [16:0] MAX_LEN = 17'd1 << ADDR_W;

    // Running frame checksum: plain XOR of every covered byte.
    function automatic logic [7:0] f_chk_update(input logic [7:0] chk,
                                                input logic [7:0] b);
        return chk ^ b;
    endfunction

    state_t            r_state;
    logic [15:0]       r_len;
    logic [16:0]       r_word_cnt;
    logic [1:0]        r_byte_cnt;
    logic [7:0]        r_chk;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_cpu_hold;
    logic              r_done;
    logic              r_error;

    logic              w_byte_ready;
    logic              w_accept;
    logic [15:0]       w_len_full;
    logic [16:0]       w_word_cnt_nxt;

    // The only cycle a byte cannot be taken is the memory write cycle.
    assign w_byte_ready   = (r_state != ST_WRITE);
    assign w_accept       = bus.byte_valid & w_byte_ready;
    assign w_len_full     = {r_len[15:8], bus.byte_in};
    assign w_word_cnt_nxt = r_word_cnt + 17'd1;

    assign bus.byte_ready = w_byte_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.cpu_hold   = r_cpu_hold;
    assign bus.done       = r_done;
    assign bus.error      = r_error;

    // Frame parser FSM with all registered outputs updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_len       <= 16'd0;
            r_word_cnt  <= 17'd0;
            r_byte_cnt  <= 2'd0;
            r_chk       <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_cpu_hold  <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                // Waiting for a frame; DONE/ERROR keep their flags until a new SYNC.
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (w_accept && (bus.byte_in == SYNC)) begin
                        r_state    <= ST_LEN_HI;
                        r_cpu_hold <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_mem_addr <= '0;
                        r_chk      <= 8'd0;
                        r_word_cnt <= 17'd0;
                        r_byte_cnt <= 2'd0;
                    end
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= bus.byte_in;
                        r_chk       <= f_chk_update(r_chk, bus.byte_in);
                        r_state     <= ST_LEN_LO;
                    end
                end
                // Length is validated before any write so mem_addr cannot wrap mid-frame.
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_len <= w_len_full;
                        r_chk <= f_chk_update(r_chk, bus.byte_in);
                        if ({1'b0, w_len_full} > MAX_LEN) begin
                            r_error <= 1'b1;
                            r_state <= ST_ERROR;
                        end else if (w_len_full == 16'd0) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_mem_wdata <= {r_mem_wdata[23:0], bus.byte_in};
                        r_chk       <= f_chk_update(r_chk, bus.byte_in);
                        r_byte_cnt  <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_we <= 1'b1;
                            r_state  <= ST_WRITE;
                        end
                    end
                end
                // Single write cycle; address advances only after the strobe.
                ST_WRITE: begin
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= r_mem_addr + 1'b1;
                    r_word_cnt <= w_word_cnt_nxt;
                    if (w_word_cnt_nxt == {1'b0, r_len}) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_state <= ST_DATA;
                    end
                end
                ST_CHECK: begin
                    if (w_accept) begin
                        if (bus.byte_in == r_chk) begin
                            r_done     <= 1'b1;
                            r_cpu_hold <= 1'b0;
                            r_state    <= ST_DONE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ST_ERROR;
                        end
                    end
                end
                default: begin
                    r_mem_we <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: framed streams with hand-computed
// expected writes, checksum outcomes and status flags.
module tb_program_loader;
    localparam int unsigned ADDR_W = 10;

    logic clk = 1'b0;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    logic [ADDR_W-1:0] q_addr [$];
    logic [31:0]       q_data [$];
    int                we_ready_viol = 0;
    int                we_long = 0;
    logic              prev_we = 1'b0;

    // Reload frame; 8'h23 is the XOR of 00 01 DE AD BE EF.
    logic [7:0] reload_fr [8] = '{8'hA5, 8'h00, 8'h01, 8'hDE,
                                  8'hAD, 8'hBE, 8'hEF, 8'h23};

    program_loader_if #(.ADDR_W(ADDR_W)) bus ();

    program_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Record every write strobe mid-cycle and flag strobes that look wrong.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            q_addr.push_back(bus.mem_addr);
            q_data.push_back(bus.mem_wdata);
            if (bus.byte_ready) we_ready_viol <= we_ready_viol + 1;
            if (prev_we) we_long <= we_long + 1;
        end
        prev_we <= bus.mem_we;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one byte and return 1ns after the edge that transfers it.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && waited < 16) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 16) check_eq("byte_ready_timeout", 32'(waited), 32'd0);
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic expect_status(input string tag, input logic hold,
                                 input logic dn, input logic er);
        check_eq({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'(hold));
        check_eq({tag, "_done"},     32'(bus.done),     32'(dn));
        check_eq({tag, "_error"},    32'(bus.error),    32'(er));
    endtask

    task automatic expect_reset(input string tag);
        check_eq({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd1);
        check_eq({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
        check_eq({tag, "_mem_addr"},   32'(bus.mem_addr),   32'd0);
        check_eq({tag, "_mem_wdata"},  bus.mem_wdata,       32'd0);
        expect_status(tag, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clear_writes();
        q_addr.delete();
        q_data.delete();
    endtask

    // Two-word frame 12345678 / 9ABCDEF0 with a caller-chosen checksum byte.
    task automatic run_two_word(input string tag, input logic [7:0] chk_byte);
        logic [7:0] fr [12];
        fr = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
               8'h9A, 8'hBC, 8'hDE, 8'hF0, chk_byte};
        clear_writes();
        for (int i = 0; i < 12; i++) begin
            send_byte(fr[i], 0);
            if (i == 0) expect_status({tag, "_sync"}, 1'b1, 1'b0, 1'b0);
            if (i == 6) begin
                check_eq({tag, "_w0_we"},    32'(bus.mem_we),     32'd1);
                check_eq({tag, "_w0_ready"}, 32'(bus.byte_ready), 32'd0);
                check_eq({tag, "_w0_addr"},  32'(bus.mem_addr),   32'd0);
                check_eq({tag, "_w0_data"},  bus.mem_wdata,       32'h12345678);
            end
            if (i == 10) begin
                check_eq({tag, "_w1_we"},    32'(bus.mem_we),     32'd1);
                check_eq({tag, "_w1_ready"}, 32'(bus.byte_ready), 32'd0);
                check_eq({tag, "_w1_addr"},  32'(bus.mem_addr),   32'd1);
                check_eq({tag, "_w1_data"},  bus.mem_wdata,       32'h9ABCDEF0);
            end
        end
        check_eq({tag, "_nwrites"}, 32'(q_addr.size()), 32'd2);
    endtask

    function automatic logic [31:0] word_of(input int i);
        return 32'(i) * 32'h0103_0507 + 32'h1357_9BDF;
    endfunction

    initial begin
        logic [7:0]  sum;
        logic [31:0] w;
        int          bad;

        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        rst_n          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_reset("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Good frame
        run_two_word("good", 8'h02);
        expect_status("good_end", 1'b0, 1'b1, 1'b0);

        // Bad checksum: writes still happen, then error with pipeline held
        run_two_word("badchk", 8'h03);
        expect_status("badchk_end", 1'b1, 1'b0, 1'b1);

        // Length overflow: 0x0401 words exceeds 1024
        clear_writes();
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        check_eq("ovf_error_before", 32'(bus.error), 32'd0);
        send_byte(8'h01, 0);
        expect_status("ovf", 1'b1, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check_eq("ovf_nwrites", 32'(q_addr.size()), 32'd0);

        // Garbage is discarded, then a zero-length frame
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        expect_status("garbage", 1'b1, 1'b0, 1'b1);
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        expect_status("zero_len", 1'b0, 1'b1, 1'b0);
        check_eq("zero_len_nwrites", 32'(q_addr.size()), 32'd0);

        // Reload with random valid gaps
        clear_writes();
        for (int i = 0; i < 8; i++) begin
            send_byte(reload_fr[i], int'($urandom_range(4)));
            if (i == 0) expect_status("reload_sync", 1'b1, 1'b0, 1'b0);
        end
        expect_status("reload_end", 1'b0, 1'b1, 1'b0);
        check_eq("reload_nwrites", 32'(q_addr.size()), 32'd1);
        if (q_addr.size() == 1) begin
            check_eq("reload_addr", 32'(q_addr[0]), 32'd0);
            check_eq("reload_data", q_data[0], 32'hDEADBEEF);
        end

        // Reset in the middle of a frame, then a clean reload
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        expect_status("midframe", 1'b1, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        expect_reset("async_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_two_word("after_reset", 8'h02);
        expect_status("after_reset_end", 1'b0, 1'b1, 1'b0);

        // Full-capacity frame: 1024 words, address wraps to 0 after the last write
        clear_writes();
        sum = 8'h04 ^ 8'h00;
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        check_eq("full_len_error", 32'(bus.error), 32'd0);
        for (int i = 0; i < 1024; i++) begin
            w = word_of(i);
            for (int k = 3; k >= 0; k--) begin
                send_byte(w[k*8 +: 8], 0);
                sum = sum ^ w[k*8 +: 8];
            end
        end
        send_byte(sum, 0);
        expect_status("full_end", 1'b0, 1'b1, 1'b0);
        check_eq("full_nwrites", 32'(q_addr.size()), 32'd1024);
        check_eq("full_addr_wrapped", 32'(bus.mem_addr), 32'd0);
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++) begin
            if (q_addr[i] !== ADDR_W'(i) || q_data[i] !== word_of(i)) bad++;
        end
        check_eq("full_seq_errors", 32'(bad), 32'd0);

        check_eq("we_while_ready", 32'(we_ready_viol), 32'd0);
        check_eq("we_pulse_width", 32'(we_long), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
